// File: rtl/pcs_os_pkg.sv
// -----------------------------------------------------------------------------
// pcs_os_pkg
// Definitions shared by the PCS transmit and receive ordered-set logic:
//   - 8b code-group constants for the control and idle code-groups
//   - one-hot ordered-set class codes (same encoding on tx_o_set / rx_o_set)
//   - receive ordered-set FSM state encodings (one-hot)
//   - helper that recognises the second code-group of an /I/ ordered set
// No ports (package).
// -----------------------------------------------------------------------------
package pcs_os_pkg;

  // Control code-groups (rx_is_k = 1)
  localparam logic [7:0] K28_5 = 8'hBC;  // comma, first octet of /I/
  localparam logic [7:0] K27_7 = 8'hFB;  // /S/ start of packet
  localparam logic [7:0] K29_7 = 8'hFD;  // /T/ end of packet
  localparam logic [7:0] K23_7 = 8'hF7;  // /R/ carrier extend

  // Data code-groups (rx_is_k = 0) completing an /I/ ordered set
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;

  // One-hot ordered-set classes
  localparam logic [4:0] OS_NONE = 5'b00000;
  localparam logic [4:0] OS_R    = 5'b00001;
  localparam logic [4:0] OS_S    = 5'b00010;
  localparam logic [4:0] OS_T    = 5'b00100;
  localparam logic [4:0] OS_D    = 5'b01000;
  localparam logic [4:0] OS_I    = 5'b10000;

  // Receive FSM states, one-hot
  typedef enum logic [4:0] {
    RX_WAIT_FOR_K = 5'b00001,
    RX_IDLE_D     = 5'b00010,
    RX_IDLE       = 5'b00100,
    RX_RECEIVE    = 5'b01000,
    RX_TRI_RRI    = 5'b10000
  } rx_state_e;

  // True when the code-group is a valid second half of /I/ (D5.6 or D16.2)
  function automatic logic is_idle_data(input logic is_k, input logic [7:0] cg);
    return !is_k && ((cg == D5_6) || (cg == D16_2));
  endfunction

endpackage

// File: rtl/pcs_rx_stat_cnt.sv
// -----------------------------------------------------------------------------
// pcs_rx_stat_cnt
// Saturating statistics counter. Counts one per clock while en_i is high,
// holds at all-ones, and clears only on reset.
// Ports:
//   clk_i   in   1      clock, posedge
//   rst_ni  in   1      asynchronous active-low reset
//   en_i    in   1      count enable
//   cnt_o   out  CNT_W  current count
// -----------------------------------------------------------------------------
module pcs_rx_stat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pcs_rx_ordered_set.sv
// -----------------------------------------------------------------------------
// pcs_rx_ordered_set
// Receive-side PCS ordered-set FSM. Classifies decoded code-groups into
// /I/ /S/ /D/ /T/ /R/ and rebuilds GMII RXD / RX_DV / RX_ER. All outputs are
// registered: a code-group accepted at edge n shows on the outputs after it.
// Optional statistics counters are built only when PCS_RX_STATS_EN is defined;
// otherwise pkt_cnt / err_cnt are tied to zero.
// Ports:
//   clk            in   1      clock, posedge
//   mr_main_reset  in   1      asynchronous active-low reset
//   rx_valid       in   1      decoder in sync, code-group valid
//   rx_is_k        in   1      code-group is a control (K) symbol
//   rx_code_group  in   8      decoded octet
//   RXD            out  8      received data octet
//   RX_DV          out  1      receive data valid
//   RX_ER          out  1      receive error
//   rx_o_set       out  5      one-hot ordered-set class (0 = invalid)
//   pkt_cnt        out  CNT_W  frames ended by /T/ (saturating)
//   err_cnt        out  CNT_W  cycles with RX_ER=1 (saturating)
// -----------------------------------------------------------------------------
module pcs_rx_ordered_set
  import pcs_os_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [7:0] PREAMBLE = 8'h55
) (
  input  logic             clk,
  input  logic             mr_main_reset,
  input  logic             rx_valid,
  input  logic             rx_is_k,
  input  logic [7:0]       rx_code_group,
  output logic [7:0]       RXD,
  output logic             RX_DV,
  output logic             RX_ER,
  output logic [4:0]       rx_o_set,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  rx_state_e  state_q, state_d;
  logic [7:0] rxd_q,   rxd_d;
  logic       dv_q,    dv_d;
  logic       er_q,    er_d;
  logic [4:0] oset_q,  oset_d;
`ifdef PCS_RX_STATS_EN
  logic       pkt_end_d;
`endif

  logic is_comma;
  assign is_comma = rx_is_k && (rx_code_group == K28_5);

  always_comb begin
    state_d = state_q;
    rxd_d   = '0;
    dv_d    = 1'b0;
    er_d    = 1'b0;
    oset_d  = OS_NONE;
`ifdef PCS_RX_STATS_EN
    pkt_end_d = 1'b0;
`endif
    if (!rx_valid) begin
      // Loss of sync aborts any frame; flag the abort only if one was open.
      state_d = RX_WAIT_FOR_K;
      er_d    = (state_q == RX_RECEIVE);
    end else begin
      case (state_q)
        RX_WAIT_FOR_K: begin
          if (is_comma) state_d = RX_IDLE_D;
        end
        RX_IDLE_D: begin
          if (is_idle_data(rx_is_k, rx_code_group)) begin
            state_d = RX_IDLE;
            oset_d  = OS_I;
          end else begin
            state_d = RX_WAIT_FOR_K;
          end
        end
        RX_IDLE: begin
          if (is_comma) begin
            state_d = RX_IDLE_D;
          end else if (rx_is_k && (rx_code_group == K27_7)) begin
            state_d = RX_RECEIVE;
            rxd_d   = PREAMBLE;
            dv_d    = 1'b1;
            oset_d  = OS_S;
          end else begin
            state_d = RX_WAIT_FOR_K;
          end
        end
        RX_RECEIVE: begin
          if (!rx_is_k) begin
            rxd_d  = rx_code_group;
            dv_d   = 1'b1;
            oset_d = OS_D;
          end else if (rx_code_group == K29_7) begin
            state_d = RX_TRI_RRI;
            oset_d  = OS_T;
`ifdef PCS_RX_STATS_EN
            pkt_end_d = 1'b1;
`endif
          end else if (is_comma) begin
            // Frame cut short by idle: close it with a one-cycle error.
            state_d = RX_IDLE_D;
            er_d    = 1'b1;
          end else begin
            // Unexpected K inside a frame (includes a second /S/).
            rxd_d = rx_code_group;
            dv_d  = 1'b1;
            er_d  = 1'b1;
          end
        end
        RX_TRI_RRI: begin
          if (rx_is_k && (rx_code_group == K23_7)) begin
            oset_d = OS_R;
          end else if (is_comma) begin
            state_d = RX_IDLE_D;
          end else begin
            state_d = RX_WAIT_FOR_K;
          end
        end
        default: state_d = RX_WAIT_FOR_K;
      endcase
    end
  end

  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q <= RX_WAIT_FOR_K;
      rxd_q   <= '0;
      dv_q    <= 1'b0;
      er_q    <= 1'b0;
      oset_q  <= OS_NONE;
    end else begin
      state_q <= state_d;
      rxd_q   <= rxd_d;
      dv_q    <= dv_d;
      er_q    <= er_d;
      oset_q  <= oset_d;
    end
  end

  assign RXD      = rxd_q;
  assign RX_DV    = dv_q;
  assign RX_ER    = er_q;
  assign rx_o_set = oset_q;

`ifdef PCS_RX_STATS_EN
  // Enables use the next-state values so the counts move with the outputs.
  pcs_rx_stat_cnt #(.CNT_W(CNT_W)) u_pkt_cnt (
    .clk_i  (clk),
    .rst_ni (mr_main_reset),
    .en_i   (pkt_end_d),
    .cnt_o  (pkt_cnt)
  );

  pcs_rx_stat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk_i  (clk),
    .rst_ni (mr_main_reset),
    .en_i   (er_d),
    .cnt_o  (err_cnt)
  );
`else
  assign pkt_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_pcs_rx_ordered_set.sv
module tb_pcs_rx_ordered_set;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [4:0] XR = 5'b00001, XS = 5'b00010, XT = 5'b00100,
                         XD = 5'b01000, XI = 5'b10000, XN = 5'b00000;

  logic             clk = 1'b0;
  logic             mr_main_reset;
  logic             rx_valid, rx_is_k;
  logic [7:0]       rx_code_group;
  logic [7:0]       RXD;
  logic             RX_DV, RX_ER;
  logic [4:0]       rx_o_set;
  logic [CNT_W-1:0] pkt_cnt, err_cnt;

  pcs_rx_ordered_set #(.CNT_W(CNT_W), .PREAMBLE(8'h55)) dut (
    .clk           (clk),
    .mr_main_reset (mr_main_reset),
    .rx_valid      (rx_valid),
    .rx_is_k       (rx_is_k),
    .rx_code_group (rx_code_group),
    .RXD           (RXD),
    .RX_DV         (RX_DV),
    .RX_ER         (RX_ER),
    .rx_o_set      (rx_o_set),
    .pkt_cnt       (pkt_cnt),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Link phases: hunting for a comma, comma seen, idle, inside frame, after /T/.
  typedef enum int { HUNT, GOT_COMMA, LINK_IDLE, IN_FRAME, AFTER_TERM } phase_e;
  phase_e     m_phase;
  logic [7:0] e_rxd;
  logic       e_dv, e_er;
  logic [4:0] e_os;
  int         e_pkt, e_err;

  task automatic model_reset();
    m_phase = HUNT;
    e_rxd = 8'h00; e_dv = 1'b0; e_er = 1'b0; e_os = XN;
    e_pkt = 0; e_err = 0;
  endtask

  task automatic model_step(input logic v, input logic k, input logic [7:0] cg);
    bit comma, start, term, ext, idle2;
    comma = k && cg == 8'hBC;
    start = k && cg == 8'hFB;
    term  = k && cg == 8'hFD;
    ext   = k && cg == 8'hF7;
    idle2 = !k && (cg == 8'hC5 || cg == 8'h50);
    e_rxd = 8'h00; e_dv = 1'b0; e_er = 1'b0; e_os = XN;
    if (!v) begin
      e_er    = (m_phase == IN_FRAME);
      m_phase = HUNT;
    end else if (m_phase == IN_FRAME) begin
      if (!k) begin
        e_rxd = cg; e_dv = 1'b1; e_os = XD;
      end else if (term) begin
        e_os = XT; m_phase = AFTER_TERM; e_pkt++;
      end else if (comma) begin
        e_er = 1'b1; m_phase = GOT_COMMA;
      end else begin
        e_rxd = cg; e_dv = 1'b1; e_er = 1'b1;
      end
    end else if (m_phase == GOT_COMMA) begin
      if (idle2) begin e_os = XI; m_phase = LINK_IDLE; end
      else m_phase = HUNT;
    end else if (m_phase == LINK_IDLE && start) begin
      e_rxd = 8'h55; e_dv = 1'b1; e_os = XS; m_phase = IN_FRAME;
    end else if (m_phase == AFTER_TERM && ext) begin
      e_os = XR;
    end else begin
      m_phase = comma ? GOT_COMMA : HUNT;
    end
    if (e_er) e_err++;
    if (e_pkt > CNT_MAX) e_pkt = CNT_MAX;
    if (e_err > CNT_MAX) e_err = CNT_MAX;
  endtask

  function automatic int exp_cnt(input int c);
`ifdef PCS_RX_STATS_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic check_all(input string name, input logic [7:0] w_rxd, input logic w_dv,
                           input logic w_er, input logic [4:0] w_os);
    checks++;
    if (RXD !== w_rxd || RX_DV !== w_dv || RX_ER !== w_er || rx_o_set !== w_os ||
        int'(pkt_cnt) != exp_cnt(e_pkt) || int'(err_cnt) != exp_cnt(e_err)) begin
      failures++;
      $display("FAIL %s: got rxd=%h dv=%b er=%b os=%b pkt=%0d err=%0d want rxd=%h dv=%b er=%b os=%b pkt=%0d err=%0d",
               name, RXD, RX_DV, RX_ER, rx_o_set, pkt_cnt, err_cnt,
               w_rxd, w_dv, w_er, w_os, exp_cnt(e_pkt), exp_cnt(e_err));
    end
  endtask

  // Apply one code-group, step the model and sample just after the edge.
  task automatic apply(input logic v, input logic k, input logic [7:0] cg);
    rx_valid = v; rx_is_k = k; rx_code_group = cg;
    @(posedge clk);
    #1;
    model_step(v, k, cg);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       v, k;
    logic [7:0] cg;
    logic [7:0] rxd;
    logic       dv, er;
    logic [4:0] os;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic k, input logic [7:0] cg,
                     input logic [7:0] rxd, input logic dv, input logic er, input logic [4:0] os);
    vec_t e;
    e.v = v; e.k = k; e.cg = cg; e.rxd = rxd; e.dv = dv; e.er = er; e.os = os;
    tbl.push_back(e);
  endtask

  initial begin
    // Frame: I x2, /S/, 3 data, /T/, /R/, /I/
    add(1,1,8'hBC, 8'h00,0,0,XN); add(1,0,8'h50, 8'h00,0,0,XI);
    add(1,1,8'hBC, 8'h00,0,0,XN); add(1,0,8'h50, 8'h00,0,0,XI);
    add(1,1,8'hFB, 8'h55,1,0,XS); add(1,0,8'h01, 8'h01,1,0,XD);
    add(1,0,8'h02, 8'h02,1,0,XD); add(1,0,8'h03, 8'h03,1,0,XD);
    add(1,1,8'hFD, 8'h00,0,0,XT); add(1,1,8'hF7, 8'h00,0,0,XR);
    add(1,1,8'hBC, 8'h00,0,0,XN); add(1,0,8'hC5, 8'h00,0,0,XI);
    // Early end
    add(1,1,8'hFB, 8'h55,1,0,XS); add(1,0,8'hAA, 8'hAA,1,0,XD);
    add(1,1,8'hBC, 8'h00,0,1,XN); add(1,0,8'hC5, 8'h00,0,0,XI);
    // Bad K in frame
    add(1,1,8'hFB, 8'h55,1,0,XS); add(1,0,8'h11, 8'h11,1,0,XD);
    add(1,1,8'hF7, 8'hF7,1,1,XN); add(1,0,8'h22, 8'h22,1,0,XD);
    add(1,1,8'hFD, 8'h00,0,0,XT);
    // Back-to-back: T R I S
    add(1,1,8'hF7, 8'h00,0,0,XR); add(1,1,8'hBC, 8'h00,0,0,XN);
    add(1,0,8'hC5, 8'h00,0,0,XI); add(1,1,8'hFB, 8'h55,1,0,XS);
    add(1,0,8'h33, 8'h33,1,0,XD); add(1,1,8'hFD, 8'h00,0,0,XT);
    // Sync loss mid-frame, then /S/ without idle is ignored
    add(1,1,8'hBC, 8'h00,0,0,XN); add(1,0,8'hC5, 8'h00,0,0,XI);
    add(1,1,8'hFB, 8'h55,1,0,XS); add(1,0,8'h44, 8'h44,1,0,XD);
    add(0,0,8'h00, 8'h00,0,1,XN); add(1,1,8'hFB, 8'h00,0,0,XN);
    add(1,0,8'h55, 8'h00,0,0,XN); add(1,0,8'hC5, 8'h00,0,0,XN);
    // Two more frames; second /S/ inside a frame is an error K
    add(1,1,8'hBC, 8'h00,0,0,XN); add(1,0,8'hC5, 8'h00,0,0,XI);
    add(1,1,8'hFB, 8'h55,1,0,XS); add(1,1,8'hFB, 8'hFB,1,1,XN);
    add(1,1,8'hFD, 8'h00,0,0,XT);
    add(1,1,8'hBC, 8'h00,0,0,XN); add(1,0,8'h50, 8'h00,0,0,XI);
    add(1,1,8'hFB, 8'h55,1,0,XS); add(1,1,8'hFD, 8'h00,0,0,XT);

    // ---------------- reset ----------------
    mr_main_reset = 1'b0;
    rx_valid = 1'b0; rx_is_k = 1'b0; rx_code_group = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_state", 8'h00, 1'b0, 1'b0, XN);
    @(negedge clk);
    mr_main_reset = 1'b1;

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].k, tbl[i].cg);
      check_all($sformatf("table[%0d]", i), tbl[i].rxd, tbl[i].dv, tbl[i].er, tbl[i].os);
    end

    // Five frames ended by /T/: saturates at 3 with CNT_W=2
    checks++;
    if (int'(pkt_cnt) != exp_cnt(3)) begin
      failures++;
      $display("FAIL pkt_cnt_sat: got %0d want %0d", pkt_cnt, exp_cnt(3));
    end

    // ---------------- reset mid-frame ----------------
    apply(1,1,8'hBC); apply(1,0,8'hC5); apply(1,1,8'hFB); apply(1,0,8'h66);
    check_all("pre_reset_frame", 8'h66, 1'b1, 1'b0, XD);
    @(negedge clk);
    mr_main_reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset_drop", 8'h00, 1'b0, 1'b0, XN);
    @(posedge clk);
    @(negedge clk);
    mr_main_reset = 1'b1;
    apply(1,1,8'hFB);
    check_all("s_after_reset_ignored", 8'h00, 1'b0, 1'b0, XN);
    apply(1,1,8'hBC); apply(1,0,8'hC5);
    apply(1,1,8'hFB);
    check_all("s_after_idle", 8'h55, 1'b1, 1'b0, XS);

    // ---------------- randomized vs model ----------------
    @(negedge clk);
    mr_main_reset = 1'b0;
    model_reset();
    @(negedge clk);
    mr_main_reset = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic       v, k;
      logic [7:0] cg;
      int         sel;
      v   = ($urandom_range(0, 40) != 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: begin k = 1; cg = 8'hBC; end
        2:    begin k = 1; cg = 8'hFB; end
        3:    begin k = 1; cg = 8'hFD; end
        4:    begin k = 1; cg = 8'hF7; end
        5:    begin k = 0; cg = 8'hC5; end
        6:    begin k = 0; cg = 8'h50; end
        7:    begin k = 1; cg = 8'($urandom); end
        default: begin k = 0; cg = 8'($urandom); end
      endcase
      apply(v, k, cg);
      check_all($sformatf("rand[%0d]", n), e_rxd, e_dv, e_er, e_os);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
